// File: rtl/data_if_initiator_pkg.sv
// Shared types for the data-memory initiator: request/response payloads,
// tracking entries and the request-register FSM encoding.
package data_if_initiator_pkg;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned BE_W   = 8;
    // Internal tag storage width; the top's ID_WIDTH must not exceed this.
    localparam int unsigned TAG_W  = 16;

    typedef enum logic {
        IDLE,
        WAIT_GNT
    } req_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
        logic [TAG_W-1:0]  id;
    } mem_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              we;
        logic [TAG_W-1:0]  id;
    } mem_rsp_t;

    // What must be remembered about a granted transaction until its rvalid.
    typedef struct packed {
        logic [TAG_W-1:0] id;
        logic             we;
    } trk_t;

    // Stores return no data upstream; the bus rdata is meaningless for them.
    function automatic logic [DATA_W-1:0] rsp_data(input logic we, input logic [DATA_W-1:0] rdata);
        return we ? '0 : rdata;
    endfunction

endpackage

// File: rtl/data_if_initiator_sync_fifo.sv
// Generic synchronous FIFO with occupancy count. Push and pop may happen in
// the same cycle, also when full (the popped slot is reused).
module sync_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter type         T     = logic,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  T                 wdata_i,
    input  logic             pop_i,
    output T                 rdata_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                 mem_q [DEPTH];
    T                 mem_d [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            mem_d[wptr_q] = wdata_i;
            wptr_d        = ptr_inc(wptr_q);
        end
        if (do_pop) begin
            rptr_d = ptr_inc(rptr_q);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Storage is reset too so the head output reads 0 while empty after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q   <= '{default: '0};
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/data_if_initiator.sv
// Initiator side of the core data-memory req/gnt/rvalid port. Upstream
// requests land in a single request register that is held on the bus until
// granted; grants are credit-limited so every rvalid always has a free slot
// in the response FIFO, which returns data upstream in order.
module data_if_initiator
    import data_if_initiator_pkg::*;
#(
    parameter int unsigned NR_OUTSTANDING = 2,
    parameter int unsigned ID_WIDTH       = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    // upstream request
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [63:0]         req_addr_i,
    input  logic                req_we_i,
    input  logic [7:0]          req_be_i,
    input  logic [63:0]         req_wdata_i,
    input  logic [ID_WIDTH-1:0] req_id_i,
    // upstream response
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [63:0]         rsp_rdata_o,
    output logic                rsp_we_o,
    output logic [ID_WIDTH-1:0] rsp_id_o,
    // memory port
    output logic                data_req_o,
    output logic [63:0]         data_addr_o,
    output logic                data_we_o,
    output logic [7:0]          data_be_o,
    output logic [63:0]         data_wdata_o,
    input  logic                data_gnt_i,
    input  logic                data_rvalid_i,
    input  logic [63:0]         data_rdata_i
);

    localparam int unsigned CNT_W = $clog2(NR_OUTSTANDING + 1);

    req_state_e       state_q, state_d;
    mem_req_t         req_q, req_d, new_req;
    logic [CNT_W-1:0] inflight_q, inflight_d;

    logic             req_hs, grant, rvalid_ok, rsp_pop, credit_ok;
    logic [CNT_W:0]   used_cnt;

    trk_t             trk_push_data, trk_head;
    logic             trk_empty, trk_full;
    logic [CNT_W-1:0] trk_count;

    mem_rsp_t         rsp_push_data, rsp_head;
    logic             rsp_empty, rsp_full;
    logic [CNT_W-1:0] rsp_count;

    // A response leaving this cycle frees its credit immediately; without
    // this, a minimum-latency stream would stall every third cycle at
    // NR_OUTSTANDING=2. Counts only ever rise through our own grant, so a
    // raised data_req_o can never lose its credit before being granted.
    assign rsp_pop   = ~rsp_empty & rsp_ready_i;
    assign used_cnt  = {1'b0, inflight_q} + {1'b0, rsp_count} - {{CNT_W{1'b0}}, rsp_pop};
    assign credit_ok = used_cnt < (CNT_W+1)'(NR_OUTSTANDING);

    assign data_req_o   = (state_q == WAIT_GNT) & credit_ok;
    assign grant        = data_req_o & data_gnt_i;
    assign data_addr_o  = req_q.addr;
    assign data_we_o    = req_q.we;
    assign data_be_o    = req_q.be;
    assign data_wdata_o = req_q.wdata;

    // Gated by reset so every output reads 0 while rst_ni is low.
    assign req_ready_o = rst_ni & ((state_q == IDLE) | grant);
    assign req_hs      = req_valid_i & req_ready_o;

    // An rvalid with nothing outstanding (e.g. left over from before a
    // reset) has no owner and is dropped.
    assign rvalid_ok = data_rvalid_i & (inflight_q != '0);

    assign new_req = '{
        addr:  req_addr_i,
        we:    req_we_i,
        be:    req_be_i,
        wdata: req_wdata_i,
        id:    TAG_W'(req_id_i)
    };

    // Request register FSM: load on handshake, hold until granted, reload
    // in the grant cycle for back-to-back issue.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        unique case (state_q)
            IDLE: begin
                if (req_hs) begin
                    req_d   = new_req;
                    state_d = WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                if (grant) begin
                    if (req_hs) begin
                        req_d = new_req;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // In-flight count: granted but rvalid not yet seen.
    always_comb begin
        inflight_d = inflight_q;
        unique case ({grant, rvalid_ok})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // State, request register and in-flight counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            req_q      <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            inflight_q <= inflight_d;
        end
    end

    assign trk_push_data = '{id: req_q.id, we: req_q.we};

    sync_fifo #(
        .DEPTH (NR_OUTSTANDING),
        .T     (trk_t)
    ) u_trk_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (grant),
        .wdata_i (trk_push_data),
        .pop_i   (rvalid_ok),
        .rdata_o (trk_head),
        .empty_o (trk_empty),
        .full_o  (trk_full),
        .count_o (trk_count)
    );

    assign rsp_push_data = '{
        rdata: rsp_data(trk_head.we, data_rdata_i),
        we:    trk_head.we,
        id:    trk_head.id
    };

    sync_fifo #(
        .DEPTH (NR_OUTSTANDING),
        .T     (mem_rsp_t)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (rvalid_ok),
        .wdata_i (rsp_push_data),
        .pop_i   (rsp_pop),
        .rdata_o (rsp_head),
        .empty_o (rsp_empty),
        .full_o  (rsp_full),
        .count_o (rsp_count)
    );

    assign rsp_valid_o = ~rsp_empty;
    assign rsp_rdata_o = rsp_head.rdata;
    assign rsp_we_o    = rsp_head.we;
    assign rsp_id_o    = rsp_head.id[ID_WIDTH-1:0];

`ifndef SYNTHESIS
    a_req_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        data_req_o && !data_gnt_i |=> data_req_o)
        else $error("data_if_initiator: data_req_o dropped without grant");

    a_payload_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        data_req_o && !data_gnt_i |=> $stable(data_addr_o) && $stable(data_we_o)
                                      && $stable(data_be_o) && $stable(data_wdata_o))
        else $error("data_if_initiator: payload changed while waiting for grant");

    a_stray_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        data_rvalid_i |-> inflight_q != '0)
        else $warning("data_if_initiator: rvalid with nothing in flight ignored");

    a_trk_consistent: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (inflight_q == trk_count) && (trk_empty == (inflight_q == '0)))
        else $error("data_if_initiator: tracking FIFO out of step with in-flight count");

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rsp_full && rvalid_ok && !rsp_pop) && !(trk_full && grant && !rvalid_ok))
        else $error("data_if_initiator: FIFO overflow");

    a_tag_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !rsp_empty |-> (rsp_head.id >> ID_WIDTH) == '0)
        else $error("data_if_initiator: tag exceeds ID_WIDTH");
`endif

endmodule

// File: tb/tb_data_if_initiator.sv
// Directed bench for data_if_initiator. A transaction-level model (queues of
// accepted requests and expected responses plus credit counts) is checked
// against the DUT every cycle; each test also pins latencies and values
// with hand-computed literals.
module tb_data_if_initiator;

    localparam int N = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i, req_ready_o;
    logic [63:0] req_addr_i;
    logic        req_we_i;
    logic [7:0]  req_be_i;
    logic [63:0] req_wdata_i;
    logic [3:0]  req_id_i;
    logic        rsp_valid_o, rsp_ready_i;
    logic [63:0] rsp_rdata_o;
    logic        rsp_we_o;
    logic [3:0]  rsp_id_o;
    logic        data_req_o;
    logic [63:0] data_addr_o;
    logic        data_we_o;
    logic [7:0]  data_be_o;
    logic [63:0] data_wdata_o;
    logic        data_gnt_i, data_rvalid_i;
    logic [63:0] data_rdata_i;

    data_if_initiator #(.NR_OUTSTANDING(N), .ID_WIDTH(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_we_i(req_we_i), .req_be_i(req_be_i), .req_wdata_i(req_wdata_i), .req_id_i(req_id_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_we_o(rsp_we_o), .rsp_id_o(rsp_id_o),
        .data_req_o(data_req_o), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
        .data_be_o(data_be_o), .data_wdata_o(data_wdata_o), .data_gnt_i(data_gnt_i),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [63:0] addr; logic we; logic [7:0] be; logic [63:0] wdata; logic [3:0] id; } req_t;
    typedef struct { logic [63:0] rdata; logic we; logic [3:0] id; } rsp_t;
    typedef struct { logic [63:0] addr; logic we; } mem_op_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // model state
    req_t    pay_q[$];
    rsp_t    exp_q[$];
    mem_op_t rq[$];
    int      og, inflight_m, avail, gnt_cnt;
    int      acc_cyc[16], gnt_cyc[16], pop_cyc[16];
    logic [63:0] last_rdata;
    logic        last_we;
    logic [3:0]  last_id;

    // responder controls
    logic gnt_en, rv_en, force_stray;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bench memory contents for loads.
    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        if (a == 64'h8000_0010) return 64'hDEAD_BEEF_0000_0001;
        return {a[31:0] ^ 32'h5A5A_0F0F, ~a[31:0]};
    endfunction

    // Memory responder: grant per gnt_en, rvalid one cycle after each grant.
    initial begin
        logic g;
        mem_op_t e;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            g = data_req_o & data_gnt_i;
            if (!rst_ni) rq.delete();
            else if (g) rq.push_back('{addr: data_addr_o, we: data_we_o});
            @(posedge clk_i);
            #2;
            data_gnt_i = gnt_en;
            if (force_stray) begin
                data_rvalid_i = 1'b1; data_rdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
            end else if (rv_en && rq.size() > 0) begin
                e = rq.pop_front();
                data_rvalid_i = 1'b1;
                data_rdata_i  = e.we ? 64'hFFFF_0000_FFFF_0000 : mem_rd(e.addr);
            end else begin
                data_rvalid_i = 1'b0; data_rdata_i = '0;
            end
        end
    end

    // Compare process: check DUT against the model, then advance the model.
    initial begin
        bit exp_req, exp_ready, acc, gr, rv, pp;
        req_t r;
        rsp_t x;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                chk("reset_req_ready", req_ready_o, 0);
                chk("reset_data_req", data_req_o, 0);
                chk("reset_rsp_valid", rsp_valid_o, 0);
                chk("reset_data_addr", data_addr_o, 0);
                chk("reset_rsp_rdata", rsp_rdata_o, 0);
                pay_q.delete(); exp_q.delete();
                og = 0; inflight_m = 0; avail = 0;
            end else begin
                exp_req   = (pay_q.size() > 0) && ((og - ((avail > 0 && rsp_ready_i) ? 1 : 0)) < N);
                exp_ready = (pay_q.size() == 0) || (exp_req && data_gnt_i);
                chk("data_req", data_req_o, exp_req);
                if (exp_req) begin
                    chk("data_addr", data_addr_o, pay_q[0].addr);
                    chk("data_we", data_we_o, pay_q[0].we);
                    chk("data_be", data_be_o, pay_q[0].be);
                    chk("data_wdata", data_wdata_o, pay_q[0].wdata);
                end
                chk("req_ready", req_ready_o, exp_ready);
                chk("rsp_valid", rsp_valid_o, avail > 0);
                if (avail > 0) begin
                    chk("rsp_rdata", rsp_rdata_o, exp_q[0].rdata);
                    chk("rsp_we", rsp_we_o, exp_q[0].we);
                    chk("rsp_id", rsp_id_o, exp_q[0].id);
                end
                acc = req_valid_i && exp_ready;
                gr  = exp_req && data_gnt_i;
                rv  = data_rvalid_i && (inflight_m > 0);
                pp  = (avail > 0) && rsp_ready_i;
                if (acc) begin
                    r = '{addr: req_addr_i, we: req_we_i, be: req_be_i, wdata: req_wdata_i, id: req_id_i};
                    pay_q.push_back(r);
                    exp_q.push_back('{rdata: req_we_i ? 64'h0 : mem_rd(req_addr_i), we: req_we_i, id: req_id_i});
                    acc_cyc[req_id_i] = cyc;
                end
                if (gr) begin
                    r = pay_q.pop_front();
                    gnt_cyc[r.id] = cyc;
                    og++; inflight_m++; gnt_cnt++;
                end
                if (rv) begin
                    inflight_m--; avail++;
                end
                if (pp) begin
                    x = exp_q.pop_front();
                    pop_cyc[x.id] = cyc;
                    last_rdata = rsp_rdata_o; last_we = rsp_we_o; last_id = rsp_id_o;
                    avail--; og--;
                end
            end
        end
    end

    task automatic send(input logic [63:0] a, input logic we, input logic [7:0] be,
                        input logic [63:0] wd, input logic [3:0] id);
        int t = 0;
        req_addr_i = a; req_we_i = we; req_be_i = be; req_wdata_i = wd; req_id_i = id;
        req_valid_i = 1'b1;
        forever begin
            @(negedge clk_i);
            if (req_ready_o) break;
            t++;
            if (t > 200) begin
                chk("send_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || pay_q.size() != 0) && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        chk("idle_timeout", exp_q.size() + pay_q.size(), 0);
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        rst_ni = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; req_we_i = 1'b0;
        req_be_i = '0; req_wdata_i = '0; req_id_i = '0; rsp_ready_i = 1'b1;
        gnt_en = 1'b1; rv_en = 1'b1; force_stray = 1'b0; gnt_cnt = 0;
        cycles(3);
        rst_ni = 1'b1;
        cycles(2);

        // single load, minimum latency
        send(64'h8000_0010, 1'b0, 8'hFF, 64'h0, 4'd3);
        wait_idle();
        chk("t1_req_latency", gnt_cyc[3] - acc_cyc[3], 1);
        chk("t1_rsp_latency", pop_cyc[3] - acc_cyc[3], 3);
        chk("t1_rdata", last_rdata, 64'hDEAD_BEEF_0000_0001);
        chk("t1_id", last_id, 4'd3);
        chk("t1_we", last_we, 1'b0);

        // grant stall on a store
        gnt_en = 1'b0;
        send(64'h8000_0020, 1'b1, 8'h0F, 64'h1122_3344_5566_7788, 4'd7);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("t2_req_held", data_req_o, 1);
            chk("t2_ready_low", req_ready_o, 0);
            chk("t2_addr", data_addr_o, 64'h8000_0020);
            chk("t2_be", data_be_o, 8'h0F);
            chk("t2_wdata", data_wdata_o, 64'h1122_3344_5566_7788);
            @(posedge clk_i);
            #1;
        end
        gnt_en = 1'b1;
        wait_idle();
        chk("t2_ack_we", last_we, 1'b1);
        chk("t2_ack_rdata", last_rdata, 64'h0);
        chk("t2_ack_id", last_id, 4'd7);

        // credit limit with upstream back-pressure
        rsp_ready_i = 1'b0;
        g0 = gnt_cnt;
        send(64'h100, 1'b0, 8'hFF, 64'h0, 4'd1);
        send(64'h108, 1'b0, 8'hFF, 64'h0, 4'd2);
        send(64'h110, 1'b0, 8'hFF, 64'h0, 4'd3);
        cycles(6);
        @(negedge clk_i);
        chk("t3_grants", gnt_cnt - g0, 2);
        chk("t3_req_blocked", data_req_o, 0);
        chk("t3_rsp_head", rsp_id_o, 4'd1);
        @(posedge clk_i);
        #1;
        rsp_ready_i = 1'b1;
        wait_idle();
        chk("t3_order", pop_cyc[2] - pop_cyc[1], 1);
        chk("t3_id3_after", (gnt_cyc[3] >= pop_cyc[1]) ? 1 : 0, 1);
        chk("t3_id3_last", (pop_cyc[3] > pop_cyc[2]) ? 1 : 0, 1);

        // back-to-back loads, full throughput
        for (int i = 8; i < 16; i++) begin
            send(64'h1000 + 64'(i * 8), 1'b0, 8'hFF, 64'h0, 4'(i));
        end
        wait_idle();
        chk("t4_gnt_span", gnt_cyc[15] - gnt_cyc[8], 7);
        chk("t4_pop_span", pop_cyc[15] - pop_cyc[8], 7);

        // grant, rvalid and pop in one cycle
        send(64'h2000, 1'b0, 8'hFF, 64'h0, 4'd3);
        send(64'h2008, 1'b0, 8'hFF, 64'h0, 4'd4);
        send(64'h2010, 1'b0, 8'hFF, 64'h0, 4'd5);
        wait_idle();
        chk("t5_gnt_gap", gnt_cyc[5] - gnt_cyc[4], 1);
        chk("t5_pop3_with_gnt5", pop_cyc[3], gnt_cyc[5]);
        chk("t5_pop4", pop_cyc[4] - gnt_cyc[5], 1);
        chk("t5_pop5", pop_cyc[5] - pop_cyc[4], 1);

        // reset mid-operation
        rv_en = 1'b0;
        send(64'h3000, 1'b0, 8'hFF, 64'h0, 4'd6);
        cycles(3);
        gnt_en = 1'b0;
        send(64'h3008, 1'b0, 8'hFF, 64'h0, 4'd7);
        cycles(2);
        chk("t6_pre_req", data_req_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_req", data_req_o, 0);
        chk("t6_rst_ready", req_ready_o, 0);
        chk("t6_rst_rsp_valid", rsp_valid_o, 0);
        chk("t6_rst_addr", data_addr_o, 0);
        cycles(2);
        rst_ni = 1'b1;
        rv_en = 1'b1; gnt_en = 1'b1;
        cycles(1);
        force_stray = 1'b1;
        cycles(1);
        force_stray = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("t6_no_stray_rsp", rsp_valid_o, 0);
        end
        cycles(1);
        send(64'h4000, 1'b0, 8'hFF, 64'h0, 4'd9);
        wait_idle();
        chk("t6_new_id", last_id, 4'd9);
        chk("t6_new_rdata", last_rdata, 64'h5A5A_4F0F_FFFF_BFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_if_initiator.md
Name: data_if_initiator

Overview:
- Initiator (master) side of the core data memory req/gnt/rvalid interface; drives the port that the core memory model / dp_ram-backed responder serves.
- Accepts load/store operations from an upstream valid/ready source and issues them on the memory port.
- Holds each request stable until granted and tracks in-flight transactions.
- Returns in-order read data/write acks upstream through a response buffer, so the never-stalling rvalid is always absorbed.

Parameters:
NR_OUTSTANDING, 2, max transactions granted-but-not-consumed upstream (in-flight + buffered); power of two, >=1
ID_WIDTH, 4, width of upstream transaction tag

Ports:
- Clock/reset:
  clk_i  in  1  clock
  rst_ni  in  1  asynchronous active-low reset
- Upstream request:
  req_valid_i  in  1  upstream request valid
  req_ready_o  out  1  request accepted when valid&ready
  req_addr_i  in  64  byte address
  req_we_i  in  1  1=store, 0=load
  req_be_i  in  8  byte enables
  req_wdata_i  in  64  store data
  req_id_i  in  ID_WIDTH  tag returned with response
- Upstream response:
  rsp_valid_o  out  1  response valid
  rsp_ready_i  in  1  upstream consumes response
  rsp_rdata_o  out  64  load data (store: 0)
  rsp_we_o  out  1  response belongs to a store
  rsp_id_o  out  ID_WIDTH  tag of the response
- Memory port:
  data_req_o  out  1  memory request
  data_addr_o  out  64  address
  data_we_o  out  1  write enable
  data_be_o  out  8  byte enables
  data_wdata_o  out  64  write data
  data_gnt_i  in  1  grant, same cycle as data_req_o
  data_rvalid_i  in  1  response valid, >=1 cycle after gnt, in order
  data_rdata_i  in  64  read data, qualified by rvalid

Behaviour:
- Reset (rst_ni asynchronous, active-low; clock clk_i):
  - all outputs 0, request register empty, in-flight counter 0, response FIFO empty.
  - Reset mid-transaction drops everything; any rvalid after reset release with zero in-flight is ignored.
- Request register FSM, states IDLE / WAIT_GNT:
  - IDLE: data_req_o=0; req_ready_o=1. Handshake loads the register -> WAIT_GNT.
  - WAIT_GNT: data_req_o=1 only when credit_ok, else 0. data_addr/we/be/wdata_o are driven from the register and remain stable.
  - data_req_o never deasserts without gnt once raised; guaranteed because credits only decrease via own grant.
  - On data_req_o&data_gnt_i the register empties. req_ready_o=1 in the same cycle, allowing back-to-back issue: new request loads; state stays WAIT_GNT. Otherwise -> IDLE.
  - req_ready_o = (state==IDLE) | (data_req_o & data_gnt_i).
- Credits:
  - credit_ok = (inflight_cnt + fifo_count) < NR_OUTSTANDING.
  - inflight_cnt +1 on grant, -1 on rvalid; simultaneous grant and rvalid leaves it unchanged.
- Tracking FIFO (depth NR_OUTSTANDING): on grant push {id, we}; on rvalid pop head.
- Response FIFO (depth NR_OUTSTANDING):
  - on rvalid push {rdata (0 if we), we, id}.
  - rsp_valid_o = !empty; pop on rsp_valid_o&rsp_ready_i.
  - Push and pop in the same cycle are allowed, including when full. Overflow is impossible by credits.
- Minimum latency:
  - accept at cycle 0 -> data_req_o at cycle 1.
  - gnt at 1, rvalid at 2 -> rsp_valid_o at 3.
  - Steady-state throughput is 1 transaction/cycle when NR_OUTSTANDING>=2 and upstream is always ready.
- Protocol errors: rvalid with inflight_cnt==0 is ignored and flagged by a simulation-only assertion. Assertions also cover data_req_o dropping without gnt and payload changing while data_req_o&!data_gnt_i.
- Data widths are fixed at 64-bit / 8 byte lanes; the address is passed unmodified. The block performs no alignment checking.

Decomposition:
- Shared package:
  - struct mem_req_t {addr, we, be, wdata, id}
  - struct mem_rsp_t {rdata, we, id}
  - FSM enum {IDLE, WAIT_GNT}
- One generic sub-module, sync_fifo (parameterised depth and type, count output), instantiated twice: tracking and response.

Test Plan:
- Single load: addr 0x8000_0010, id 3, gnt immediate, rvalid next cycle with 0xDEAD_BEEF_0000_0001 -> data_req_o at cycle 1; rsp_valid_o at cycle 3 with that rdata, id 3, we 0.
- Grant stall: store addr 0x8000_0020, be 0x0F, wdata 0x1122_3344_5566_7788, gnt withheld 5 cycles -> data_req_o and payload held constant 5 cycles; req_ready_o=0 throughout; ack with rsp_we_o=1, rdata 0.
- Credit limit: NR_OUTSTANDING=2, rsp_ready_i=0, 3 loads ids 1,2,3 -> exactly 2 grants; data_req_o stays 0 for id 3. Raising rsp_ready_i returns ids 1,2 in order, then id 3 issues.
- Back-to-back: 8 loads with always-gnt, rvalid 1 cycle later, rsp_ready_i=1 -> one grant per cycle, 8 responses in order, no bubbles after fill.
- Simultaneous events: grant of id 5 in the same cycle as rvalid for id 4 and a response pop -> inflight_cnt unchanged, correct order 4 then 5.
- Reset mid-operation: assert rst_ni low while WAIT_GNT with 1 in flight -> all outputs 0 immediately. After release, a stray rvalid produces no response, and a new load completes normally.
